wb_master_interface: RTL and testbench



---
 rtl/wb_master_interface.sv | 174 +++++++++++++++++
 tb/tb_wb_master_interface.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_interface.sv
// rtl/wb_master_interface.sv - Wishbone B4 pipelined single-beat initiator behind a valid/ready request/response channel
// Optional feature macro: WB_MASTER_TIMEOUT_EN (ack timeout with error response, TIMEOUT_CYCLES parameter)
module wb_master_interface #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_we_i,
   input  logic [3:0]  req_sel_i,
   input  logic [31:0] req_data_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        wb_cyc_o,
   input  logic        wb_stall_i
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_WAIT_ACK,
      ST_RESPOND
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_cyc, w_cyc_nxt;
   logic        r_stb, w_stb_nxt;
   logic        r_we, w_we_nxt;
   logic [31:0] r_adr, w_adr_nxt;
   logic [31:0] r_dat, w_dat_nxt;
   logic [3:0]  r_sel, w_sel_nxt;
   logic        r_rsp_valid, w_rsp_valid_nxt;
   logic [31:0] r_rsp_data, w_rsp_data_nxt;
   logic        w_ack_ok;

`ifdef WB_MASTER_TIMEOUT_EN
   logic [15:0] r_tmo_cnt, w_tmo_cnt_nxt;
   logic        r_rsp_err, w_rsp_err_nxt;
   logic        w_timeout;

   assign w_timeout = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign rsp_err_o = r_rsp_err;
`else
   assign rsp_err_o = 1'b0;
`endif

   // An ack only counts once the strobe has been accepted (or in the same cycle it is)
   assign w_ack_ok = ((r_state == ST_REQUEST) && !wb_stall_i && wb_ack_i) ||
                     ((r_state == ST_WAIT_ACK) && wb_ack_i);

   assign req_ready_o = (r_state == ST_IDLE);
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;
   assign wb_adr_o    = r_adr;
   assign wb_dat_o    = r_dat;
   assign wb_we_o     = r_we;
   assign wb_sel_o    = r_sel;
   assign wb_stb_o    = r_stb;
   assign wb_cyc_o    = r_cyc;

   // Next-state and next-output logic for the single-beat bus cycle
   always_comb begin
      w_state_nxt     = r_state;
      w_cyc_nxt       = r_cyc;
      w_stb_nxt       = r_stb;
      w_we_nxt        = r_we;
      w_adr_nxt       = r_adr;
      w_dat_nxt       = r_dat;
      w_sel_nxt       = r_sel;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_data_nxt  = r_rsp_data;
`ifdef WB_MASTER_TIMEOUT_EN
      w_rsp_err_nxt   = r_rsp_err;
      w_tmo_cnt_nxt   = r_tmo_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            if (req_valid_i) begin
               w_adr_nxt   = req_addr_i;
               w_dat_nxt   = req_data_i;
               w_we_nxt    = req_we_i;
               w_sel_nxt   = req_sel_i;
               w_cyc_nxt   = 1'b1;
               w_stb_nxt   = 1'b1;
               w_state_nxt = ST_REQUEST;
`ifdef WB_MASTER_TIMEOUT_EN
               w_tmo_cnt_nxt = 16'd0;
`endif
            end
         end
         ST_REQUEST, ST_WAIT_ACK: begin
            if (w_ack_ok) begin
               w_cyc_nxt       = 1'b0;
               w_stb_nxt       = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_data_nxt  = r_we ? 32'd0 : wb_dat_i;
               w_state_nxt     = ST_RESPOND;
`ifdef WB_MASTER_TIMEOUT_EN
               w_rsp_err_nxt   = 1'b0;
`endif
            end else begin
               if ((r_state == ST_REQUEST) && !wb_stall_i) begin
                  w_stb_nxt   = 1'b0;
                  w_state_nxt = ST_WAIT_ACK;
               end
`ifdef WB_MASTER_TIMEOUT_EN
               if (w_timeout) begin
                  w_cyc_nxt       = 1'b0;
                  w_stb_nxt       = 1'b0;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_err_nxt   = 1'b1;
                  w_rsp_data_nxt  = 32'd0;
                  w_state_nxt     = ST_RESPOND;
               end else begin
                  w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
               end
`endif
            end
         end
         ST_RESPOND: begin
            if (rsp_ready_i) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any bus cycle in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_cyc       <= 1'b0;
         r_stb       <= 1'b0;
         r_we        <= 1'b0;
         r_adr       <= 32'd0;
         r_dat       <= 32'd0;
         r_sel       <= 4'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 32'd0;
`ifdef WB_MASTER_TIMEOUT_EN
         r_rsp_err   <= 1'b0;
         r_tmo_cnt   <= 16'd0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cyc       <= w_cyc_nxt;
         r_stb       <= w_stb_nxt;
         r_we        <= w_we_nxt;
         r_adr       <= w_adr_nxt;
         r_dat       <= w_dat_nxt;
         r_sel       <= w_sel_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
`ifdef WB_MASTER_TIMEOUT_EN
         r_rsp_err   <= w_rsp_err_nxt;
         r_tmo_cnt   <= w_tmo_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_wb_master_interface.sv
// tb/tb_wb_master_interface.sv - scoreboard bench for wb_master_interface with randomized requests and responder
module tb_wb_master_interface;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      int          nst;
      int          lat;
      logic [31:0] rd;
      int          h;
   } req_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          t;
   } rsp_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        req_we_i;
   logic [3:0]  req_sel_i;
   logic [31:0] req_data_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic        wb_cyc_o;
   logic        wb_stall_i;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cnt = 0;
   int   outstanding = 0;
   int   ready_pct = 100;
   bit   hang_mode = 0;
   bit   rsp_started = 0;

   wb_master_interface #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .req_we_i(req_we_i), .req_sel_i(req_sel_i), .req_data_i(req_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o),
      .wb_stall_i(wb_stall_i)
   );

   initial forever #5 clk_i = ~clk_i;
   initial forever begin @(posedge clk_i); cnt++; end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cnt);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cnt);
   endtask

   task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int nst, input int lat, input logic [31:0] rd, output int h);
      req_t r;
      bit   got = 0;
      r.we = we; r.addr = a; r.data = d; r.sel = s; r.nst = nst; r.lat = lat; r.rd = rd; r.h = 0;
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_data_i = d; req_sel_i = s;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk_i);
         if (req_ready_o) got = 1;
      end
      if (!got) begin
         fail_now("req_handshake_timeout");
         req_valid_i = 1'b0;
         h = -1;
         return;
      end
      r.h = cnt + 1;
      h = r.h;
      req_q.push_back(r);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      req_addr_i = $urandom; req_data_i = $urandom; req_we_i = 1'($urandom); req_sel_i = 4'($urandom);
      outstanding++;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500 && outstanding != 0; i++) begin @(posedge clk_i); #1; end
      if (outstanding != 0) fail_now("wait_idle_timeout");
   endtask

   task automatic chk_bus(input req_t r, input logic stb_exp);
      chk("bus_cyc", wb_cyc_o, 1'b1);
      chk("bus_stb", wb_stb_o, stb_exp);
      chk("bus_adr", wb_adr_o, r.addr);
      chk("bus_dat", wb_dat_o, r.data);
      chk("bus_sel", wb_sel_o, r.sel);
      chk("bus_we", wb_we_o, r.we);
   endtask

   task automatic serve();
      req_t r;
      rsp_t e;
      if (req_q.size() == 0) begin
         fail_now("unexpected_cyc");
         wb_ack_i = 1'b0; wb_stall_i = 1'b0;
         return;
      end
      r = req_q.pop_front();
      chk("stb_start_cycle", cnt, r.h);
      if (hang_mode) begin
         wb_stall_i = 1'b0; wb_ack_i = 1'b0;
         for (int i = 0; i < 100 && wb_cyc_o && !rst_i; i++) begin @(posedge clk_i); #1; end
         return;
      end
      e.data = r.we ? 32'd0 : r.rd;
      e.err = 1'b0;
      e.t = r.h + r.nst + r.lat + 1;
      rsp_q.push_back(e);
      for (int k = 0; k < r.nst; k++) begin
         wb_stall_i = 1'b1; wb_ack_i = 1'($urandom); wb_dat_i = $urandom;
         chk_bus(r, 1'b1);
         @(posedge clk_i); #1;
      end
      wb_stall_i = 1'b0; wb_ack_i = (r.lat == 0); wb_dat_i = (r.lat == 0) ? r.rd : $urandom;
      chk_bus(r, 1'b1);
      @(posedge clk_i); #1;
      for (int j = 1; j <= r.lat; j++) begin
         wb_stall_i = 1'($urandom); wb_ack_i = (j == r.lat); wb_dat_i = (j == r.lat) ? r.rd : $urandom;
         chk_bus(r, 1'b0);
         @(posedge clk_i); #1;
      end
      wb_ack_i = 1'b0; wb_stall_i = 1'b0;
      chk("cyc_drop", wb_cyc_o, 1'b0);
      chk("stb_drop", wb_stb_o, 1'b0);
   endtask

   // Responder: spurious acks while idle, scripted stall/latency per transfer otherwise
   initial begin
      wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'd0;
      forever begin
         @(posedge clk_i); #1;
         if (!rst_i && wb_cyc_o) serve();
         else begin
            wb_ack_i = ($urandom_range(0, 3) == 0);
            wb_stall_i = 1'($urandom);
            wb_dat_i = $urandom;
         end
      end
   end

   // Response consumer back-pressure
   initial begin
      rsp_ready_i = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         rsp_ready_i = ($urandom_range(0, 99) < ready_pct);
      end
   end

   // Monitor: request gating and response scoreboard
   initial forever begin
      rsp_t e;
      @(negedge clk_i);
      if (!rst_i) begin
         chk("req_ready", req_ready_o, outstanding == 0);
         if (rsp_valid_o) begin
            if (rsp_q.size() == 0) fail_now("unexpected_rsp");
            else begin
               e = rsp_q[0];
               if (!rsp_started) begin
                  chk("rsp_latency", cnt, e.t);
                  rsp_started = 1;
               end
               chk("rsp_data", rsp_data_o, e.data);
               chk("rsp_err", rsp_err_o, e.err);
               if (rsp_ready_i) begin
                  void'(rsp_q.pop_front());
                  rsp_started = 0;
                  @(posedge clk_i); #1;
                  outstanding--;
               end
            end
         end
      end
   end

   initial begin
      #400000;
      fail_now("global_watchdog");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int h;
      bit seen;
      rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = 32'd0; req_we_i = 1'b0;
      req_sel_i = 4'd0; req_data_i = 32'd0;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_cyc", wb_cyc_o, 1'b0);
      chk("rst_stb", wb_stb_o, 1'b0);
      chk("rst_we", wb_we_o, 1'b0);
      chk("rst_adr", wb_adr_o, 32'd0);
      chk("rst_dat", wb_dat_o, 32'd0);
      chk("rst_sel", wb_sel_o, 4'd0);
      chk("rst_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_rsp_data", rsp_data_o, 32'd0);
      chk("rst_rsp_err", rsp_err_o, 1'b0);
      chk("rst_req_ready", req_ready_o, 1'b1);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      do_req(1'b0, 32'h0000_0004, $urandom, 4'hF, 0, 1, 32'h0000_0003, h);
      wait_idle();
      do_req(1'b1, 32'h0000_000C, 32'h0000_0041, 4'hF, 3, 1, 32'hDEAD_BEEF, h);
      wait_idle();
      do_req(1'b0, $urandom, $urandom, 4'($urandom), 0, 0, $urandom, h);
      wait_idle();

      ready_pct = 0;
      do_req(1'b0, $urandom, $urandom, 4'($urandom), 1, 2, $urandom, h);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk_i); seen = rsp_valid_o; end
      if (!seen) fail_now("hold_rsp_valid_timeout");
      repeat (5) @(negedge clk_i);
      ready_pct = 100;
      @(posedge clk_i); #1;
      do_req(1'b1, $urandom, $urandom, 4'($urandom), 0, 1, $urandom, h);
      wait_idle();

      ready_pct = 60;
      for (int n = 0; n < 150; n++) begin
         do_req(1'($urandom), $urandom, $urandom, 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom, h);
         repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      end
      wait_idle();

      ready_pct = 100;
      hang_mode = 1;
      do_req(1'b0, $urandom, $urandom, 4'hF, 0, 0, 32'd0, h);
      repeat (3) begin @(posedge clk_i); #1; end
      chk("hang_cyc_high", wb_cyc_o, 1'b1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      outstanding = 0;
      rsp_started = 0;
      chk("midrst_cyc", wb_cyc_o, 1'b0);
      chk("midrst_stb", wb_stb_o, 1'b0);
      chk("midrst_req_ready", req_ready_o, 1'b1);
      chk("midrst_rsp_valid", rsp_valid_o, 1'b0);
      repeat (5) begin @(posedge clk_i); #1; chk("midrst_no_rsp", rsp_valid_o, 1'b0); end
      hang_mode = 0;

`ifdef WB_MASTER_TIMEOUT_EN
      begin
         rsp_t e;
         hang_mode = 1;
         do_req(1'b0, $urandom, $urandom, 4'hF, 0, 0, 32'd0, h);
         e.data = 32'd0; e.err = 1'b1; e.t = h + 8;
         rsp_q.push_back(e);
         seen = 0;
         for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk_i); seen = !wb_cyc_o; end
         chk("tmo_cyc_drop_cycle", cnt, h + 8);
         wait_idle();
         hang_mode = 0;
      end
`endif

      repeat (3) begin @(posedge clk_i); #1; end
      chk("req_q_drained", req_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
